regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the core register file.
- Provides configurable width and depth, RPORTS combinational read ports and two prioritised write ports.
- Adds optional write-to-read bypass and a per-register busy scoreboard that tracks in-flight writeback producers.
- Sits between decode/issue (reads, busy check, issue marking) and writeback (two result buses) in the pipelined cores.

Parameters:
- XLEN, 32: register data width in bits.
- NREGS, 32: number of architectural registers; power of two, ≥2. AW = $clog2(NREGS).
- RPORTS, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_num  in  RPORTS*AW  packed read register numbers; port i at bits [i*AW +: AW].
- rd_value  out  RPORTS*XLEN  packed read data, combinational.
- rd_busy  out  RPORTS  per-port busy flag for the addressed register, combinational.
- wr0_en  in  1  write port 0 enable.
- wr0_num  in  AW  write port 0 register number.
- wr0_value  in  XLEN  write port 0 data.
- wr1_en  in  1  write port 1 enable; has priority over port 0.
- wr1_num  in  AW  write port 1 register number.
- wr1_value  in  XLEN  write port 1 data.
- issue_en  in  1  mark a register as having an in-flight producer.
- issue_num  in  AW  register to mark busy.
- flush  in  1  synchronous clear of all busy bits; register contents untouched.
- any_busy  out  1  registered OR of all busy bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0, all busy bits = 0, any_busy = 0.
  - Release is synchronous to clk in the surrounding design; the block needs no extra handling.
  - Reset asserted mid-write: the write is lost, and the register reads 0.
- Register 0:
  - always reads 0 and is never busy.
  - writes and issues targeting 0 are ignored; the storage may hold 0 permanently.
- Writes:
  - take effect at the rising edge when en = 1 and num != 0.
  - Both ports enabled to the same register: wr1_value stored.
  - Different registers: both stored in the same cycle.
- Reads, combinational, per port i:
  - num == 0 → 0.
  - Else if BYPASS and wr1 hits num → wr1_value.
  - Else if BYPASS and wr0 hits num → wr0_value.
  - Else the stored value.
  - A "hit" means en = 1, num equal, num != 0.
  - BYPASS = 0: a write becomes visible the cycle after the edge; read latency 0, write latency 1.
- Busy scoreboard, next-state per register r != 0, in priority order:
  - flush → 0.
  - issue_en and issue_num == r → 1. Issue beats a same-cycle writeback clear, because the new producer supersedes the old one.
  - any write hit on r → 0.
  - otherwise hold.
  - Flush with a same-cycle issue: flush wins, bit = 0.
- rd_busy[i]:
  - equals busy[num_i] at num_i != 0.
  - If BYPASS = 1, it is forced to 0 when a same-cycle write hits num_i, since the data is available via bypass.
  - An issue in the same cycle is not visible until the next cycle.
  - Always 0 for num 0.
- any_busy: flop updated each edge from the next-state busy vector. It is 1 the cycle after any bit sets and 0 the cycle after all bits clear.
- Out-of-range numbers cannot occur because NREGS is a power of two.

Test Plan:
- Reset: hold rst_n = 0 with random writes/issues active → every rd_value = 0, rd_busy = 0, any_busy = 0. Release, read r1..r31 → all 0.
- Basic write/read, BYPASS = 1: wr0 r5 = 0xDEADBEEF → rd_num0 = 5 reads 0xDEADBEEF in the same cycle and the next. Write r0 = 0x1234 → r0 reads 0.
- Write collision: wr0 r7 = 0x11111111 and wr1 r7 = 0x22222222 in the same cycle → the next-cycle read of r7 returns 0x22222222. Writes r3 = 0xA and r4 = 0xB in the same cycle → both stored.
- Scoreboard: issue r9 → next cycle rd_busy = 1, any_busy = 1. Writeback r9 = 0x55 → same-cycle rd_busy = 0, data 0x55 via bypass; next cycle busy = 0, any_busy = 0.
- Issue/clear and flush priority:
  - same cycle issue r9 + wr1 r9 → r9 remains busy.
  - issue r10 + flush → r10 not busy.
  - flush with r2, r3, r4 busy → all clear next cycle; their contents unchanged.
- BYPASS = 0 build: write r6 = 0x77 → same-cycle read returns the old value 0; the next cycle returns 0x77; same-cycle rd_busy remains 1 if r6 was busy.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two prioritised write ports, optional write-to-read
// bypass and a per-register busy scoreboard for in-flight writeback producers.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int RPORTS = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RPORTS*AW-1:0]   rd_num,
    output logic [RPORTS*XLEN-1:0] rd_value,
    output logic [RPORTS-1:0]      rd_busy,
    input  logic                   wr0_en,
    input  logic [AW-1:0]          wr0_num,
    input  logic [XLEN-1:0]        wr0_value,
    input  logic                   wr1_en,
    input  logic [AW-1:0]          wr1_num,
    input  logic [XLEN-1:0]        wr1_value,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_num,
    input  logic                   flush,
    output logic                   any_busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr0_hit;
    logic             wr1_hit;
    logic             bypass_ok;

    assign wr0_hit   = wr0_en && (wr0_num != '0);
    assign wr1_hit   = wr1_en && (wr1_num != '0);
    // Forwarding is suppressed while reset is held so a write that will be lost is never seen.
    assign bypass_ok = (BYPASS != 0) && rst_n;

    always_comb begin
        busy_nxt = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (flush)
                busy_nxt[r] = 1'b0;
            else if (issue_en && (issue_num == AW'(r)))
                busy_nxt[r] = 1'b1;
            else if ((wr0_hit && (wr0_num == AW'(r))) || (wr1_hit && (wr1_num == AW'(r))))
                busy_nxt[r] = 1'b0;
            else
                busy_nxt[r] = busy[r];
        end
    end

    // Port 1 is written last so it wins when both ports target the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
            busy     <= '0;
            any_busy <= 1'b0;
        end else begin
            if (wr0_hit)
                regs[wr0_num] <= wr0_value;
            if (wr1_hit)
                regs[wr1_num] <= wr1_value;
            busy     <= busy_nxt;
            any_busy <= |busy_nxt;
        end
    end

    for (genvar i = 0; i < RPORTS; i++) begin : g_rd
        logic [AW-1:0] num;
        logic          hit0;
        logic          hit1;

        assign num  = rd_num[i*AW +: AW];
        assign hit1 = bypass_ok && wr1_hit && (wr1_num == num);
        assign hit0 = bypass_ok && wr0_hit && (wr0_num == num);

        assign rd_value[i*XLEN +: XLEN] = (num == '0) ? '0 :
                                          hit1        ? wr1_value :
                                          hit0        ? wr0_value :
                                                        regs[num];
        assign rd_busy[i] = (num != '0) && !hit1 && !hit0 && busy[num];
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Table-driven bench for regfile_mp_sb; a bypass and a non-bypass instance share stimulus.
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_num;
    logic [63:0] rd_value;
    logic [1:0]  rd_busy;
    logic        any_busy;
    logic [63:0] rd_value_nb;
    logic [1:0]  rd_busy_nb;
    logic        any_busy_nb;
    logic        wr0_en;
    logic [4:0]  wr0_num;
    logic [31:0] wr0_value;
    logic        wr1_en;
    logic [4:0]  wr1_num;
    logic [31:0] wr1_value;
    logic        issue_en;
    logic [4:0]  issue_num;
    logic        flush;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        w0e;
        logic [4:0]  w0n;
        logic [31:0] w0v;
        logic        w1e;
        logic [4:0]  w1n;
        logic [31:0] w1v;
        logic        ie;
        logic [4:0]  in;
        logic        fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        ea;
    } vec_t;

    vec_t vecs[20];
    vec_t sb_q[$];

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .RPORTS(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_num(rd_num), .rd_value(rd_value), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_num(wr0_num), .wr0_value(wr0_value),
        .wr1_en(wr1_en), .wr1_num(wr1_num), .wr1_value(wr1_value),
        .issue_en(issue_en), .issue_num(issue_num), .flush(flush), .any_busy(any_busy)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .RPORTS(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_num(rd_num), .rd_value(rd_value_nb), .rd_busy(rd_busy_nb),
        .wr0_en(wr0_en), .wr0_num(wr0_num), .wr0_value(wr0_value),
        .wr1_en(wr1_en), .wr1_num(wr1_num), .wr1_value(wr1_value),
        .issue_en(issue_en), .issue_num(issue_num), .flush(flush), .any_busy(any_busy_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string name,
                                input logic w0e, input logic [4:0] w0n, input logic [31:0] w0v,
                                input logic w1e, input logic [4:0] w1n, input logic [31:0] w1v,
                                input logic ie, input logic [4:0] in, input logic fl,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb, input logic ea);
        vec_t v;
        v.name = name; v.w0e = w0e; v.w0n = w0n; v.w0v = w0v;
        v.w1e = w1e; v.w1n = w1n; v.w1v = w1v; v.ie = ie; v.in = in; v.fl = fl;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ea = ea;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        wr0_en = v.w0e; wr0_num = v.w0n; wr0_value = v.w0v;
        wr1_en = v.w1e; wr1_num = v.w1n; wr1_value = v.w1v;
        issue_en = v.ie; issue_num = v.in; flush = v.fl;
        rd_num = {v.r1, v.r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        apply_stimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, 0, 0, 0, 0));
    endtask

    initial begin
        vec_t e;
        rst_n = 1'b1;
        idle(0, 0);
        #1 rst_n = 1'b0;

        // Reset held with random write/issue traffic: nothing may leak to the outputs.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wr0_en = 1'b1; wr0_num = 5'($urandom_range(1, 31)); wr0_value = $urandom;
            wr1_en = 1'b1; wr1_num = 5'($urandom_range(1, 31)); wr1_value = $urandom;
            issue_en = 1'b1; issue_num = 5'($urandom_range(1, 31));
            rd_num = {wr1_num, wr0_num};
            #2;
            check_output("rst_val0", rd_value[31:0], 32'h0);
            check_output("rst_val1", rd_value[63:32], 32'h0);
            check_output("rst_busy", {30'h0, rd_busy}, 32'h0);
            check_output("rst_any", {31'h0, any_busy}, 32'h0);
            check_output("rst_nb_val0", rd_value_nb[31:0], 32'h0);
        end

        @(negedge clk);
        idle(0, 0);
        rst_n = 1'b1;
        for (int r = 1; r < 32; r += 2) begin
            @(negedge clk);
            idle(5'(r), 5'(r + 1));
            #2;
            check_output("post_rst_p0", rd_value[31:0], 32'h0);
            check_output("post_rst_p1", rd_value[63:32], 32'h0);
        end

        vecs[0]  = mk("idle_read",  0,0,0,            0,0,0,            0,0,0,  1,31, 0,0,                        2'b00,0);
        vecs[1]  = mk("wr_bypass",  1,5,32'hDEADBEEF, 0,0,0,            0,0,0,  5,0,  32'hDEADBEEF,0,             2'b00,0);
        vecs[2]  = mk("wr_r0",      1,0,32'h1234,     0,0,0,            0,0,0,  5,0,  32'hDEADBEEF,0,             2'b00,0);
        vecs[3]  = mk("collide",    1,7,32'h11111111, 1,7,32'h22222222, 0,0,0,  7,5,  32'h22222222,32'hDEADBEEF,  2'b00,0);
        vecs[4]  = mk("two_writes", 1,3,32'hA,        1,4,32'hB,        0,0,0,  7,3,  32'h22222222,32'hA,         2'b00,0);
        vecs[5]  = mk("issue9",     0,0,0,            0,0,0,            1,9,0,  3,4,  32'hA,32'hB,                2'b00,0);
        vecs[6]  = mk("busy9",      0,0,0,            0,0,0,            0,0,0,  9,4,  0,32'hB,                    2'b01,1);
        vecs[7]  = mk("wb9",        0,0,0,            1,9,32'h55,       0,0,0,  9,9,  32'h55,32'h55,              2'b00,1);
        vecs[8]  = mk("after_wb9",  0,0,0,            0,0,0,            0,0,0,  9,0,  32'h55,0,                   2'b00,0);
        vecs[9]  = mk("iss_vs_wr",  0,0,0,            1,9,32'h66,       1,9,0,  9,4,  32'h66,32'hB,               2'b00,0);
        vecs[10] = mk("still_busy", 0,0,0,            0,0,0,            0,0,0,  9,9,  32'h66,32'h66,              2'b11,1);
        vecs[11] = mk("iss_flush",  0,0,0,            0,0,0,            1,10,1, 10,9, 0,32'h66,                   2'b10,1);
        vecs[12] = mk("flushed",    0,0,0,            0,0,0,            0,0,0,  10,9, 0,32'h66,                   2'b00,0);
        vecs[13] = mk("iss_r2",     0,0,0,            0,0,0,            1,2,0,  2,0,  0,0,                        2'b00,0);
        vecs[14] = mk("iss_r3",     0,0,0,            0,0,0,            1,3,0,  2,3,  0,32'hA,                    2'b01,1);
        vecs[15] = mk("iss_r4",     0,0,0,            0,0,0,            1,4,0,  3,4,  32'hA,32'hB,                2'b01,1);
        vecs[16] = mk("flush_all",  0,0,0,            0,0,0,            0,0,1,  2,4,  0,32'hB,                    2'b11,1);
        vecs[17] = mk("post_flush", 0,0,0,            0,0,0,            0,0,0,  3,4,  32'hA,32'hB,                2'b00,0);
        vecs[18] = mk("r0_traffic", 1,0,32'h99,       0,0,0,            1,0,0,  0,0,  0,0,                        2'b00,0);
        vecs[19] = mk("r0_idle",    0,0,0,            0,0,0,            0,0,0,  0,2,  0,0,                        2'b00,0);

        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            sb_q.push_back(vecs[i]);
            #2;
            e = sb_q.pop_front();
            check_output({e.name, ".val0"}, rd_value[31:0], e.e0);
            check_output({e.name, ".val1"}, rd_value[63:32], e.e1);
            check_output({e.name, ".busy"}, {30'h0, rd_busy}, {30'h0, e.eb});
            check_output({e.name, ".any"}, {31'h0, any_busy}, {31'h0, e.ea});
        end

        // Non-bypass build: write data and busy clear appear only after the edge.
        @(negedge clk);
        apply_stimulus(mk("iss_r6", 0,0,0, 0,0,0, 1,6,0, 6,6, 0,0,0,0));
        @(negedge clk);
        apply_stimulus(mk("wr_r6", 1,6,32'h77, 0,0,0, 0,0,0, 6,6, 0,0,0,0));
        #2;
        check_output("nb_same_val", rd_value_nb[31:0], 32'h0);
        check_output("nb_same_busy", {31'h0, rd_busy_nb[0]}, 32'h1);
        check_output("byp_same_val", rd_value[31:0], 32'h77);
        check_output("byp_same_busy", {31'h0, rd_busy[0]}, 32'h0);
        @(negedge clk);
        idle(6, 6);
        #2;
        check_output("nb_next_val", rd_value_nb[31:0], 32'h77);
        check_output("nb_next_busy", {31'h0, rd_busy_nb[0]}, 32'h0);
        check_output("nb_next_any", {31'h0, any_busy_nb}, 32'h0);

        // Reset asserted in the middle of a write cycle: the write must be lost.
        @(negedge clk);
        apply_stimulus(mk("wr_r12", 1,12,32'hCAFE, 0,0,0, 1,12,0, 12,5, 0,0,0,0));
        #1 rst_n = 1'b0;
        #2;
        check_output("midrst_val", rd_value[31:0], 32'h0);
        check_output("midrst_val1", rd_value[63:32], 32'h0);
        @(negedge clk);
        idle(12, 5);
        rst_n = 1'b1;
        #2;
        check_output("midrst_r12", rd_value[31:0], 32'h0);
        check_output("midrst_r5", rd_value[63:32], 32'h0);
        check_output("midrst_busy", {30'h0, rd_busy}, 32'h0);
        check_output("midrst_any", {31'h0, any_busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
